// File: rtl/fifo_flex.sv
// Single-clock FIFO on distributed registers with show-ahead or registered read,
// occupancy count, programmable almost thresholds, flush and sticky error flags.
module fifo_flex #(
   parameter int WIDTH     = 512,
   parameter int LOG_DEPTH = 9,
   parameter bit SHOWAHEAD = 1'b1,
   parameter int AF_THRESH = (1 << LOG_DEPTH) - 2,
   parameter int AE_THRESH = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 wrreq,
   input  logic [WIDTH-1:0]     data,
   input  logic                 rdreq,
   output logic [WIDTH-1:0]     q,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [LOG_DEPTH:0]   count,
   output logic                 overflow,
   output logic                 underflow
);
   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam logic [LOG_DEPTH:0]   FULL_COUNT = {1'b1, {LOG_DEPTH{1'b0}}};
   localparam logic [LOG_DEPTH:0]   AF_LEVEL   = (LOG_DEPTH+1)'(AF_THRESH);
   localparam logic [LOG_DEPTH:0]   AE_LEVEL   = (LOG_DEPTH+1)'(AE_THRESH);
   localparam logic [LOG_DEPTH:0]   CNT_ONE    = (LOG_DEPTH+1)'(1);
   localparam logic [LOG_DEPTH-1:0] PTR_ONE    = LOG_DEPTH'(1);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LOG_DEPTH:0]   count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;
   logic                 rd_ok, wr_ok, wr_acc, rd_acc;

   assign count        = count_q;
   assign empty        = (count_q == '0);
   assign full         = (count_q == FULL_COUNT);
   assign almost_full  = (count_q >= AF_LEVEL);
   assign almost_empty = (count_q <= AE_LEVEL);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   always_comb begin
      rd_ok       = rdreq && !empty;
      // A full FIFO still takes a write when a read frees the head slot this edge
      wr_ok       = wrreq && (!full || rd_ok);
      wr_acc      = wr_ok && !clear && reset_n;
      rd_acc      = rd_ok && !clear && reset_n;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q  | (wrreq && !wr_ok);
      underflow_d = underflow_q | (rdreq && empty);
      if (clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left unreset
   always_ff @(posedge clock) begin
      if (wr_acc) mem_q[wr_ptr_q] <= data;
   end

   generate
      if (SHOWAHEAD) begin : g_showahead
         assign q = mem_q[rd_ptr_q];
      end else begin : g_registered
         logic [WIDTH-1:0] dout_q, dout_d;

         always_comb begin
            dout_d = dout_q;
            if (rd_acc) dout_d = mem_q[rd_ptr_q];
         end

         always_ff @(posedge clock) begin
            if (!reset_n) dout_q <= '0;
            else          dout_q <= dout_d;
         end

         assign q = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: show-ahead and registered-read instances share stimulus and
// are checked against a queue-based reference, a directed table and random traffic.
module tb_fifo_flex;
   logic       clock = 1'b0;
   logic       reset_n, clear, wrreq, rdreq;
   logic [7:0] data;
   logic [7:0] q_sa, q_rr;
   logic       full_sa, empty_sa, af_sa, ae_sa, ovf_sa, udf_sa;
   logic       full_rr, empty_rr, af_rr, ae_rr, ovf_rr, udf_rr;
   logic [2:0] count_sa, count_rr;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mq[$];
   bit         m_ovf, m_udf;
   logic [7:0] m_rq;

   always #5 clock = ~clock;

   fifo_flex #(.WIDTH(8), .LOG_DEPTH(2), .SHOWAHEAD(1'b1), .AF_THRESH(3), .AE_THRESH(1)) dut_sa (
      .clock(clock), .reset_n(reset_n), .clear(clear), .wrreq(wrreq), .data(data),
      .rdreq(rdreq), .q(q_sa), .full(full_sa), .empty(empty_sa), .almost_full(af_sa),
      .almost_empty(ae_sa), .count(count_sa), .overflow(ovf_sa), .underflow(udf_sa));

   fifo_flex #(.WIDTH(8), .LOG_DEPTH(2), .SHOWAHEAD(1'b0), .AF_THRESH(3), .AE_THRESH(1)) dut_rr (
      .clock(clock), .reset_n(reset_n), .clear(clear), .wrreq(wrreq), .data(data),
      .rdreq(rdreq), .q(q_rr), .full(full_rr), .empty(empty_rr), .almost_full(af_rr),
      .almost_empty(ae_rr), .count(count_rr), .overflow(ovf_rr), .underflow(udf_rr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a plain queue plus sticky flags and the last word handed out
   task automatic model_check();
      int         n;
      logic [5:0] exp_flags;
      n = mq.size();
      exp_flags = {n == 0, n == 4, n >= 3, n <= 1, m_ovf, m_udf};
      chk("count_sa", {29'd0, count_sa}, n);
      chk("count_rr", {29'd0, count_rr}, n);
      chk("flags_sa", {26'd0, empty_sa, full_sa, af_sa, ae_sa, ovf_sa, udf_sa}, {26'd0, exp_flags});
      chk("flags_rr", {26'd0, empty_rr, full_rr, af_rr, ae_rr, ovf_rr, udf_rr}, {26'd0, exp_flags});
      chk("q_rr", {24'd0, q_rr}, {24'd0, m_rq});
      if (n > 0) chk("q_sa", {24'd0, q_sa}, {24'd0, mq[0]});
   endtask

   task automatic step(input bit rst_i, input bit clr_i, input bit wr_i, input bit rd_i,
                       input logic [7:0] d_i);
      bit was_empty, was_full, r_ok, w_ok;
      reset_n = rst_i; clear = clr_i; wrreq = wr_i; rdreq = rd_i; data = d_i;
      @(posedge clock);
      if (!rst_i) begin
         mq.delete(); m_ovf = 0; m_udf = 0; m_rq = 8'h00;
      end else if (clr_i) begin
         mq.delete(); m_ovf = 0; m_udf = 0;
      end else begin
         was_empty = (mq.size() == 0);
         was_full  = (mq.size() == 4);
         r_ok = rd_i && !was_empty;
         w_ok = wr_i && (!was_full || r_ok);
         if (r_ok) m_rq = mq.pop_front();
         if (w_ok) mq.push_back(d_i);
         if (wr_i && !w_ok) m_ovf = 1;
         if (rd_i && was_empty) m_udf = 1;
      end
      #1;
      model_check();
   endtask

   typedef struct {
      bit         rst_n, clr, wr, rd;
      logic [7:0] din;
      int         e_count;
      bit         qsa_v;
      logic [7:0] e_qsa, e_qrr;
      bit         e_ovf, e_udf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input bit c, input bit w, input bit rd, input logic [7:0] d,
                      input int n, input bit qv, input logic [7:0] qs, input logic [7:0] qr,
                      input bit o, input bit u);
      vec_t v;
      v = '{rst_n: r, clr: c, wr: w, rd: rd, din: d, e_count: n, qsa_v: qv,
            e_qsa: qs, e_qrr: qr, e_ovf: o, e_udf: u};
      tbl.push_back(v);
   endtask

   initial begin
      reset_n = 0; clear = 0; wrreq = 0; rdreq = 0; data = 0;
      m_ovf = 0; m_udf = 0; m_rq = 0;

      // rst clr wr rd din   cnt qv qsa   qrr  ovf udf
      add(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
      add(1, 0, 1, 0, 8'h11, 1, 1, 8'h11, 8'h00, 0, 0);
      add(1, 0, 1, 0, 8'h22, 2, 1, 8'h11, 8'h00, 0, 0);
      add(1, 0, 1, 0, 8'h33, 3, 1, 8'h11, 8'h00, 0, 0);
      add(1, 0, 1, 0, 8'h44, 4, 1, 8'h11, 8'h00, 0, 0);
      add(1, 0, 0, 1, 8'h00, 3, 1, 8'h22, 8'h11, 0, 0);
      add(1, 0, 0, 1, 8'h00, 2, 1, 8'h33, 8'h22, 0, 0);
      add(1, 0, 0, 1, 8'h00, 1, 1, 8'h44, 8'h33, 0, 0);
      add(1, 0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h44, 0, 0);
      add(1, 0, 1, 0, 8'h11, 1, 1, 8'h11, 8'h44, 0, 0);
      add(1, 0, 1, 0, 8'h22, 2, 1, 8'h11, 8'h44, 0, 0);
      add(1, 0, 1, 0, 8'h33, 3, 1, 8'h11, 8'h44, 0, 0);
      add(1, 0, 1, 0, 8'h44, 4, 1, 8'h11, 8'h44, 0, 0);
      add(1, 0, 1, 0, 8'h55, 4, 1, 8'h11, 8'h44, 1, 0);
      add(1, 0, 1, 1, 8'h66, 4, 1, 8'h22, 8'h11, 1, 0);
      add(1, 0, 0, 1, 8'h00, 3, 1, 8'h33, 8'h22, 1, 0);
      add(1, 0, 0, 1, 8'h00, 2, 1, 8'h44, 8'h33, 1, 0);
      add(1, 0, 0, 1, 8'h00, 1, 1, 8'h66, 8'h44, 1, 0);
      add(1, 0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h66, 1, 0);
      add(1, 0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h66, 1, 1);
      add(1, 0, 1, 1, 8'h77, 1, 1, 8'h77, 8'h66, 1, 1);
      add(1, 0, 1, 0, 8'h99, 2, 1, 8'h77, 8'h66, 1, 1);
      add(1, 0, 1, 0, 8'h88, 3, 1, 8'h77, 8'h66, 1, 1);
      add(1, 1, 1, 0, 8'h99, 0, 0, 8'h00, 8'h66, 0, 0);
      add(1, 0, 1, 0, 8'hB0, 1, 1, 8'hB0, 8'h66, 0, 0);
      add(1, 0, 0, 1, 8'h00, 0, 0, 8'h00, 8'hB0, 0, 0);
      add(1, 0, 1, 0, 8'hA1, 1, 1, 8'hA1, 8'hB0, 0, 0);
      add(1, 0, 1, 0, 8'hA2, 2, 1, 8'hA1, 8'hB0, 0, 0);
      add(1, 0, 0, 1, 8'h00, 1, 1, 8'hA2, 8'hA1, 0, 0);
      add(1, 0, 0, 0, 8'h00, 1, 1, 8'hA2, 8'hA1, 0, 0);
      add(1, 0, 0, 1, 8'h00, 0, 0, 8'h00, 8'hA2, 0, 0);
      add(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'hA2, 0, 0);

      @(negedge clock);
      foreach (tbl[i]) begin
         step(tbl[i].rst_n, tbl[i].clr, tbl[i].wr, tbl[i].rd, tbl[i].din);
         chk($sformatf("tbl%0d_count", i), {29'd0, count_sa}, tbl[i].e_count);
         chk($sformatf("tbl%0d_qrr", i), {24'd0, q_rr}, {24'd0, tbl[i].e_qrr});
         chk($sformatf("tbl%0d_err", i), {30'd0, ovf_sa, udf_sa}, {30'd0, tbl[i].e_ovf, tbl[i].e_udf});
         if (tbl[i].qsa_v) chk($sformatf("tbl%0d_qsa", i), {24'd0, q_sa}, {24'd0, tbl[i].e_qsa});
      end

      // Interleaved write/read pairs walking the pointers around several times
      step(0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 1, 0, 8'(i));
         step(1, 0, 0, 1, 8'h00);
         chk($sformatf("wrap_order%0d", i), {24'd0, q_rr}, i);
      end

      // Reset in the middle of a partly filled queue
      step(1, 0, 1, 0, 8'hC1);
      step(1, 0, 1, 0, 8'hC2);
      step(1, 0, 1, 1, 8'hC3);
      step(0, 0, 1, 1, 8'hC4);
      chk("rst_status_sa", {24'd0, count_sa, empty_sa, full_sa, af_sa, ae_sa, ovf_sa, udf_sa},
          {24'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      chk("rst_q_rr", {24'd0, q_rr}, 32'd0);
      step(1, 0, 1, 0, 8'hD0);
      chk("post_rst_head", {24'd0, q_sa}, 32'hD0);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 800; i++) begin
         step(($urandom % 80) != 0, ($urandom % 40) == 0, ($urandom % 3) != 0,
              ($urandom % 2) == 0, 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
